// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: runtime-loadable pattern, length and
// overlap mode, with a one-cycle match pulse and a saturating match counter.
module seq_detector_prog #(
  parameter int          MAX_LEN       = 8,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_PATTERN = 16'h000B,
  parameter int          RESET_LEN     = 4,
  parameter bit          RESET_OVERLAP = 1'b1,
  localparam int         LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  logic [MAX_LEN-1:0] r_hist, r_pat;
  logic [LEN_W-1:0]   r_fill, r_len;
  logic               r_ovl, r_match, r_armed;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_shift, w_mask, w_hist_nxt, w_pat_nxt;
  logic [LEN_W-1:0]   w_fill_inc, w_fill_nxt, w_len_nxt, w_len_clamp;
  logic               w_accept, w_hit, w_ovl_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  always_comb begin
    w_accept     = ena && bit_valid && !cfg_load;
    w_hist_shift = {r_hist[MAX_LEN-2:0], bit_in};
    w_fill_inc   = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) w_mask[i] = (i < int'(r_len));
    // Only the newest len bits are compared; the fill gate keeps stale bits out.
    w_hit = w_accept && ((w_hist_shift & w_mask) == (r_pat & w_mask)) && (w_fill_inc >= r_len);

    if (cfg_len == '0)                     w_len_clamp = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))    w_len_clamp = LEN_W'(MAX_LEN);
    else                                   w_len_clamp = cfg_len;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_ovl_nxt  = r_ovl;
    w_cnt_nxt  = r_cnt;

    if (ena) begin
      if (cfg_load) begin
        w_pat_nxt  = cfg_pattern;
        w_len_nxt  = w_len_clamp;
        w_ovl_nxt  = cfg_overlap;
        w_hist_nxt = '0;
        w_fill_nxt = '0;
      end else if (bit_valid) begin
        w_hist_nxt = w_hist_shift;
        w_fill_nxt = (w_hit && !r_ovl) ? '0 : w_fill_inc;
      end
      if (w_hit && r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
      if (count_clear)          w_cnt_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= RESET_PATTERN[MAX_LEN-1:0];
      r_len   <= LEN_W'(RESET_LEN);
      r_ovl   <= RESET_OVERLAP;
      r_cnt   <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_ovl   <= w_ovl_nxt;
      r_cnt   <= w_cnt_nxt;
      r_match <= w_hit;
      r_armed <= (w_fill_nxt >= w_len_nxt);
    end
  end

  assign match       = r_match;
  assign match_count = r_cnt;
  assign armed       = r_armed;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed test-plan steps then random
// traffic, compared against a queue-based reference model of accepted bits.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic               cfg_load = 1'b0, cfg_overlap = 1'b0, count_clear = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               match, armed, match2, armed2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clear(count_clear),
    .match(match), .match_count(match_count), .armed(armed));

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clear(count_clear),
    .match(match2), .match_count(match_count2), .armed(armed2));

  always #5 clk = ~clk;

  // Reference model: the accepted bits since the last restart, oldest first.
  bit          q[$];
  logic [15:0] m_pat;
  int          m_len;
  bit          m_ovl, m_match;
  int          m_cnt, m_cnt2;
  int          n_cmp = 0, n_err = 0;

  task automatic model_reset();
    q.delete();
    m_pat = 16'h000B; m_len = 4; m_ovl = 1'b1;
    m_match = 1'b0; m_cnt = 0; m_cnt2 = 0;
  endtask

  function automatic bit model_hit();
    if (q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  // Applies one rising edge's worth of the rules to the model, from the driven inputs.
  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (ena) begin
      if (cfg_load) begin
        m_pat = 16'(cfg_pattern);
        m_len = (cfg_len == 0) ? 1 : (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        m_ovl = cfg_overlap;
        q.delete();
      end else if (bit_valid) begin
        q.push_back(bit_in);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        hit = model_hit();
        if (hit && !m_ovl) q.delete();
      end
      if (hit) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
      if (count_clear) begin
        m_cnt = 0; m_cnt2 = 0;
      end
    end
    m_match = hit;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit m_armed;
    m_armed = (q.size() >= m_len);
    chk("match",   32'(match),        32'(m_match));
    chk("count",   32'(match_count),  32'(m_cnt));
    chk("armed",   32'(armed),        32'(m_armed));
    chk("match2",  32'(match2),       32'(m_match));
    chk("count2",  32'(match_count2), 32'(m_cnt2));
    chk("armed2",  32'(armed2),       32'(m_armed));
  endtask

  task automatic cyc(input logic e, input logic v, input logic b, input logic ld, input logic clr);
    ena = e; bit_valid = v; bit_in = b; cfg_load = ld; count_clear = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, v[i], 1'b0, 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset default pattern 1011, len 4, overlap: matches after bits 4 and 7.
    send(16'b1011011, 7);
    chk("tp1_count", 32'(match_count), 32'd2);

    // Non-overlap: a single match, armed low afterwards.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'b0000_1011, 4'd4, 1'b0);
    send(16'b1011011, 7);
    chk("tp2_count", 32'(match_count), 32'd1);

    // Pattern of ones, len 3, overlap: nine back-to-back pulses.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(8'hFF, 4'd3, 1'b1);
    send(16'b1111_1111_1110, 12);
    chk("tp3_count", 32'(match_count), 32'd9);

    // Idle and disabled cycles inside 1,0,1,1; count_clear held while disabled is ignored.
    load(8'b0000_1011, 4'd4, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp4_match", 32'(match), 32'd1);

    // len 1, pattern 1: the 2-bit counter saturates; clear on a hit cycle still pulses.
    load(8'h01, 4'd1, 1'b1);
    send(16'b111111, 6);
    chk("tp5_sat", 32'(match_count2), 32'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("tp5_clr_match", 32'(match), 32'd1);
    chk("tp5_clr_count", 32'(match_count), 32'd0);

    // cfg_len 0 behaves as len 1.
    load(8'h00, 4'd0, 1'b1);
    send(16'b1001, 4);
    // cfg_len 15 behaves as len 8.
    load(8'b1010_0110, 4'd15, 1'b0);
    send(16'b1_1010_0110_1010_011, 16);

    // Reset mid-pattern: outputs clear at once, configuration returns to 1011/4/overlap.
    load(8'h01, 4'd1, 1'b0);
    send(16'b101, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    send(16'b1, 1);
    chk("rst_nomatch", 32'(match), 32'd0);
    send(16'b011011, 6);

    // Random traffic, including loads, clears and disabled cycles.
    for (int n = 0; n < 600; n++) begin
      logic e, v, b, ld, clr;
      e   = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 4) != 0);
      b   = 1'($urandom);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      if (ld) begin
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = ($urandom_range(0, 5) == 0) ? LEN_W'($urandom_range(0, 15))
                                                  : LEN_W'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom);
      end
      cyc(e, v, b, ld, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
